// File: rtl/l1_ld_responder.sv
// L1-side PTE responder for the page walker: table lookup, fixed-latency
// response pipeline with stall, one-cycle-late cancel, and fill/invalidate port.
module l1_ld_responder #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LAT      = 1,
  parameter logic [31:0] MISS_PTE = 32'hFFFF_F000
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic [27:0]              l1_va_i,
  input  logic                     l1_va_vld_i,
  input  logic                     l1_cancel_i,
  input  logic                     stall_i,
  output logic [31:0]              l1_pa_o,
  output logic                     l1_vld_o,
  input  logic                     fill_we_i,
  input  logic [$clog2(DEPTH)-1:0] fill_idx_i,
  input  logic [31:0]              fill_data_i,
  input  logic                     inv_all_i,
  output logic [15:0]              cancel_cnt_o,
  output logic [15:0]              miss_cnt_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  // Table storage (data is never reset; validity lives in ent_vld_q)
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;

  // Response pipeline, index 0 is stage 1, index LAT-1 drives the outputs
  logic             pvld_q  [LAT];
  logic             pvld_d  [LAT];
  logic [DW-1:0]    pdata_q [LAT];
  logic [DW-1:0]    pdata_d [LAT];

  logic [CW-1:0]    cancel_cnt_q, cancel_cnt_d;
  logic [CW-1:0]    miss_cnt_q, miss_cnt_d;

  logic [IW-1:0]    rd_idx_c;
  logic             rd_hit_c;
  logic [DW-1:0]    rd_data_c;
  logic             accept_c;
  logic             cancel_c;
  logic             out_kill_c;
  logic             unused_va_c;

  // Address decode: byte offset and upper bits are ignored, aliasing intended
  assign rd_idx_c    = l1_va_i[IW+1:2];
  assign unused_va_c = ^{l1_va_i[27:IW+2], l1_va_i[1:0]};

  // Table read sees pre-edge contents, giving read-before-write on fill
  assign rd_hit_c  = ent_vld_q[rd_idx_c];
  assign rd_data_c = rd_hit_c ? mem_q[rd_idx_c] : MISS_PTE;

  assign accept_c   = l1_va_vld_i & ~stall_i;
  assign cancel_c   = l1_cancel_i & ~stall_i & pvld_q[0];
  assign out_kill_c = (LAT == 1) ? cancel_c : 1'b0;

  assign l1_pa_o      = pdata_q[LAT-1];
  assign l1_vld_o     = pvld_q[LAT-1] & ~out_kill_c;
  assign cancel_cnt_o = cancel_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

  // Entry valid bits: invalidate-all, then fill wins for its own index
  always_comb begin
    ent_vld_d = ent_vld_q;
    if (inv_all_i) begin
      ent_vld_d = '0;
    end
    if (fill_we_i) begin
      ent_vld_d[fill_idx_i] = 1'b1;
    end
  end

  // Pipeline advance; a cancel drops the stage-1 load on its way to stage 2
  always_comb begin
    for (int i = 0; i < LAT; i++) begin
      pvld_d[i]  = pvld_q[i];
      pdata_d[i] = pdata_q[i];
    end
    if (!stall_i) begin
      pvld_d[0]  = accept_c;
      pdata_d[0] = rd_data_c;
      for (int i = 1; i < LAT; i++) begin
        pvld_d[i]  = pvld_q[i-1] & ~(cancel_c & (i == 1));
        pdata_d[i] = pdata_q[i-1];
      end
    end
  end

  // Saturating event counters
  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (cancel_c && (cancel_cnt_q != '1)) begin
      cancel_cnt_d = cancel_cnt_q + CW'(1);
    end
    if (accept_c && !rd_hit_c && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CW'(1);
    end
  end

  // Table data write port
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      mem_q[fill_idx_i] <= fill_data_i;
    end
  end

  // Resettable state
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ent_vld_q    <= '0;
      cancel_cnt_q <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        pvld_q[i]  <= 1'b0;
        pdata_q[i] <= '0;
      end
    end else begin
      ent_vld_q    <= ent_vld_d;
      cancel_cnt_q <= cancel_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      for (int i = 0; i < LAT; i++) begin
        pvld_q[i]  <= pvld_d[i];
        pdata_q[i] <= pdata_d[i];
      end
    end
  end

endmodule

// File: tb/tb_l1_ld_responder.sv
// Bench for l1_ld_responder: LAT=1 and LAT=2 instances share stimulus and are
// checked against a stamp-based model of accepted loads.
module tb_l1_ld_responder;

  localparam logic [31:0] MISS = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] va = '0;
  logic        va_vld = 1'b0, cancel = 1'b0, stall = 1'b0;
  logic        fill_we = 1'b0, inv_all = 1'b0;
  logic [5:0]  fill_idx = '0;
  logic [31:0] fill_data = '0;

  logic [31:0] pa_a, pa_b;
  logic        vld_a, vld_b;
  logic [15:0] ccnt_a, ccnt_b, mcnt_a, mcnt_b;

  always #5 clk = ~clk;

  l1_ld_responder #(.DEPTH(64), .LAT(1), .MISS_PTE(MISS)) dut_a (
    .clk_i(clk), .resetn_i(rst_n), .l1_va_i(va), .l1_va_vld_i(va_vld),
    .l1_cancel_i(cancel), .stall_i(stall), .l1_pa_o(pa_a), .l1_vld_o(vld_a),
    .fill_we_i(fill_we), .fill_idx_i(fill_idx), .fill_data_i(fill_data),
    .inv_all_i(inv_all), .cancel_cnt_o(ccnt_a), .miss_cnt_o(mcnt_a));

  l1_ld_responder #(.DEPTH(64), .LAT(2), .MISS_PTE(MISS)) dut_b (
    .clk_i(clk), .resetn_i(rst_n), .l1_va_i(va), .l1_va_vld_i(va_vld),
    .l1_cancel_i(cancel), .stall_i(stall), .l1_pa_o(pa_b), .l1_vld_o(vld_b),
    .fill_we_i(fill_we), .fill_idx_i(fill_idx), .fill_data_i(fill_data),
    .inv_all_i(inv_all), .cancel_cnt_o(ccnt_b), .miss_cnt_o(mcnt_b));

  // Reference model: each accepted load is stamped with the count of
  // non-stalled edges; a LAT-L response is the load stamped nstep-L+1.
  typedef struct { logic [31:0] data; bit canc; } load_t;
  load_t       loads [int];
  logic [31:0] ref_mem [64];
  bit          ref_vld [64];
  int          nstep = 0;
  int          m_ccnt = 0, m_mcnt = 0;
  int          n_checks = 0, n_fail = 0;

  function automatic void expect_out(input int lat, output logic v,
                                     output logic [31:0] d, output bit pres);
    int s;
    s = nstep - lat + 1;
    v = 1'b0; d = '0; pres = 1'b0;
    if (loads.exists(s)) begin
      pres = 1'b1;
      d = loads[s].data;
      v = !loads[s].canc;
      if (lat == 1 && cancel && !stall) v = 1'b0;
    end
  endfunction

  // Advance one clock and apply the inputs that were presented to the model
  task automatic tick();
    int idx;
    @(posedge clk);
    if (!stall) begin
      if (cancel && loads.exists(nstep)) begin
        loads[nstep].canc = 1'b1;
        if (m_ccnt < 65535) m_ccnt++;
      end
      nstep++;
      if (va_vld) begin
        idx = int'(va[7:2]);
        loads[nstep] = '{data: (ref_vld[idx] ? ref_mem[idx] : MISS), canc: 1'b0};
        if (!ref_vld[idx] && m_mcnt < 65535) m_mcnt++;
      end
      if (loads.exists(nstep - 3)) loads.delete(nstep - 3);
    end
    if (inv_all) for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;
    if (fill_we) begin
      ref_mem[fill_idx] = fill_data;
      ref_vld[fill_idx] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    va = '0; va_vld = 1'b0; cancel = 1'b0; stall = 1'b0;
    fill_we = 1'b0; inv_all = 1'b0; fill_idx = '0; fill_data = '0;
  endtask

  task automatic fill(input int idx, input logic [31:0] data);
    idle();
    fill_we = 1'b1; fill_idx = 6'(idx); fill_data = data;
    tick();
    idle();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    loads.delete();
    m_ccnt = 0; m_mcnt = 0;
    for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;
    #2;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    assert_reset();
    n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_vld_a got=%b exp=0", vld_a); end
    n_checks++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL reset_vld_b got=%b exp=0", vld_b); end
    n_checks++; if (pa_a !== 32'h0) begin n_fail++; $display("FAIL reset_pa_a got=%h exp=0", pa_a); end
    n_checks++; if (pa_b !== 32'h0) begin n_fail++; $display("FAIL reset_pa_b got=%h exp=0", pa_b); end
    n_checks++; if (ccnt_a !== 16'h0) begin n_fail++; $display("FAIL reset_ccnt_a got=%h exp=0", ccnt_a); end
    n_checks++; if (mcnt_a !== 16'h0) begin n_fail++; $display("FAIL reset_mcnt_a got=%h exp=0", mcnt_a); end
    n_checks++; if (ccnt_b !== 16'h0) begin n_fail++; $display("FAIL reset_ccnt_b got=%h exp=0", ccnt_b); end
    n_checks++; if (mcnt_b !== 16'h0) begin n_fail++; $display("FAIL reset_mcnt_b got=%h exp=0", mcnt_b); end
    release_reset();
  endtask

  task automatic test_fill_hit();
    fill(5, 32'h0000_0ABC);
    va = 28'h14; va_vld = 1'b1;
    tick();
    idle(); #1;
    n_checks++; if (vld_a !== 1'b1 || pa_a !== 32'h0000_0ABC) begin n_fail++; $display("FAIL hit_a got=%b/%h exp=1/00000abc", vld_a, pa_a); end
    n_checks++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL hit_b_early got=%b exp=0", vld_b); end
    tick(); #1;
    n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL hit_a_t2 got=%b exp=0", vld_a); end
    n_checks++; if (vld_b !== 1'b1 || pa_b !== 32'h0000_0ABC) begin n_fail++; $display("FAIL hit_b got=%b/%h exp=1/00000abc", vld_b, pa_b); end
    tick(); #1;
    n_checks++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL hit_b_t3 got=%b exp=0", vld_b); end
  endtask

  task automatic test_miss();
    idle();
    assert_reset();
    release_reset();
    va = 28'h8; va_vld = 1'b1;
    tick();
    idle(); #1;
    n_checks++; if (vld_a !== 1'b1 || pa_a !== MISS) begin n_fail++; $display("FAIL miss_pa got=%b/%h exp=1/%h", vld_a, pa_a, MISS); end
    n_checks++; if (mcnt_a !== 16'd1 || mcnt_b !== 16'd1) begin n_fail++; $display("FAIL miss_cnt got=%0d/%0d exp=1", mcnt_a, mcnt_b); end
    tick();
  endtask

  task automatic test_cancel();
    logic ev; logic [31:0] ed; bit ep;
    logic [31:0] seen_b [$];
    int base;
    fill(1, 32'h1000_0001); fill(2, 32'h2000_0002); fill(3, 32'h3000_0003);
    base = m_ccnt;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c < 3) begin va = 28'(4 * (c + 1)); va_vld = 1'b1; end
      cancel = (c == 2);
      #1;
      expect_out(1, ev, ed, ep);
      n_checks++; if (vld_a !== ev || (ep && pa_a !== ed)) begin n_fail++; $display("FAIL cancel_a c=%0d got=%b/%h exp=%b/%h", c, vld_a, pa_a, ev, ed); end
      expect_out(2, ev, ed, ep);
      n_checks++; if (vld_b !== ev || (ev && pa_b !== ed)) begin n_fail++; $display("FAIL cancel_b c=%0d got=%b/%h exp=%b/%h", c, vld_b, pa_b, ev, ed); end
      if (vld_b) seen_b.push_back(pa_b);
      tick();
    end
    idle(); #1;
    n_checks++; if (seen_b.size() != 2 || seen_b[0] !== 32'h1000_0001 || seen_b[1] !== 32'h3000_0003) begin
      n_fail++; $display("FAIL cancel_seq got_n=%0d exp=2 (idx1, idx3)", seen_b.size()); end
    n_checks++; if (ccnt_a !== 16'(base + 1) || ccnt_b !== 16'(base + 1)) begin n_fail++; $display("FAIL cancel_cnt got=%0d/%0d exp=%0d", ccnt_a, ccnt_b, base + 1); end
    n_checks++; if (ccnt_a !== 16'(m_ccnt)) begin n_fail++; $display("FAIL cancel_cnt_mdl got=%0d exp=%0d", ccnt_a, m_ccnt); end
  endtask

  task automatic test_stall();
    int hi_cnt = 0;
    int mc;
    idle();
    va = 28'h4; va_vld = 1'b1;
    tick();
    idle(); #1;
    n_checks++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL stall_pre got=%b exp=0", vld_b); end
    tick();
    mc = m_mcnt;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c < 3) begin stall = 1'b1; va = 28'h8; va_vld = 1'b1; cancel = 1'b1; end
      #1;
      if (vld_b) hi_cnt++;
      n_checks++; if (c < 4 && (vld_b !== 1'b1 || pa_b !== 32'h1000_0001)) begin n_fail++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/10000001", c, vld_b, pa_b); end
      tick();
    end
    n_checks++; if (hi_cnt != 4) begin n_fail++; $display("FAIL stall_len got=%0d exp=4", hi_cnt); end
    n_checks++; if (mcnt_b !== 16'(mc) || ccnt_b !== 16'(m_ccnt)) begin n_fail++; $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", mcnt_b, ccnt_b, mc, m_ccnt); end
  endtask

  task automatic test_rbw();
    fill(7, 32'h1111_1007);
    fill_we = 1'b1; fill_idx = 6'd7; fill_data = 32'h2222_2007;
    va = 28'h1C; va_vld = 1'b1;
    tick();
    idle(); va = 28'h1C; va_vld = 1'b1; #1;
    n_checks++; if (vld_a !== 1'b1 || pa_a !== 32'h1111_1007) begin n_fail++; $display("FAIL rbw_old got=%b/%h exp=1/11111007", vld_a, pa_a); end
    tick();
    idle(); #1;
    n_checks++; if (vld_a !== 1'b1 || pa_a !== 32'h2222_2007) begin n_fail++; $display("FAIL rbw_new got=%b/%h exp=1/22222007", vld_a, pa_a); end
    tick();
  endtask

  task automatic test_inv();
    idle(); inv_all = 1'b1; fill_we = 1'b1; fill_idx = 6'd3; fill_data = 32'h3333_0003;
    tick();
    idle(); va = 28'h14; va_vld = 1'b1;
    tick();
    idle(); va = 28'h0C; va_vld = 1'b1; #1;
    n_checks++; if (vld_a !== 1'b1 || pa_a !== MISS) begin n_fail++; $display("FAIL inv_miss got=%b/%h exp=1/%h", vld_a, pa_a, MISS); end
    tick();
    idle(); #1;
    n_checks++; if (vld_a !== 1'b1 || pa_a !== 32'h3333_0003) begin n_fail++; $display("FAIL inv_fill_wins got=%b/%h exp=1/33330003", vld_a, pa_a); end
    tick();
  endtask

  task automatic test_reset_inflight();
    idle(); va = 28'h0C; va_vld = 1'b1; tick();
    va = 28'h0C; va_vld = 1'b1; tick();
    idle();
    assert_reset();
    n_checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin n_fail++; $display("FAIL rst_flight got=%b/%b exp=0/0", vld_a, vld_b); end
    release_reset();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin n_fail++; $display("FAIL rst_after c=%0d got=%b/%b exp=0/0", c, vld_a, vld_b); end
      tick();
    end
  endtask

  task automatic test_random();
    logic ev; logic [31:0] ed; bit ep;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) fill(i, $urandom);
    for (int c = 0; c < 400; c++) begin
      idle();
      r = $urandom;
      r[7:2] = 6'($urandom_range(0, 15));
      va = r[27:0];
      va_vld = ($urandom_range(0, 99) < 70);
      cancel = ($urandom_range(0, 99) < 20);
      stall = ($urandom_range(0, 99) < 20);
      fill_we = ($urandom_range(0, 99) < 20);
      fill_idx = 6'($urandom_range(0, 15));
      fill_data = $urandom;
      inv_all = ($urandom_range(0, 99) < 3);
      #1;
      expect_out(1, ev, ed, ep);
      n_checks++; if (vld_a !== ev || (ep && pa_a !== ed)) begin n_fail++; $display("FAIL rnd_a c=%0d got=%b/%h exp=%b/%h", c, vld_a, pa_a, ev, ed); end
      expect_out(2, ev, ed, ep);
      n_checks++; if (vld_b !== ev || (ev && pa_b !== ed)) begin n_fail++; $display("FAIL rnd_b c=%0d got=%b/%h exp=%b/%h", c, vld_b, pa_b, ev, ed); end
      n_checks++; if (ccnt_a !== 16'(m_ccnt) || ccnt_b !== 16'(m_ccnt) || mcnt_a !== 16'(m_mcnt) || mcnt_b !== 16'(m_mcnt)) begin
        n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d", c, ccnt_a, ccnt_b, mcnt_a, mcnt_b, m_ccnt, m_mcnt); end
      tick();
    end
  endtask

  task automatic test_saturation();
    idle();
    assert_reset();
    release_reset();
    va = 28'h0; va_vld = 1'b1; cancel = 1'b1;
    repeat (65540) tick();
    idle(); #1;
    n_checks++; if (ccnt_a !== 16'hFFFF || ccnt_b !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ccnt got=%h/%h exp=ffff", ccnt_a, ccnt_b); end
    n_checks++; if (mcnt_a !== 16'hFFFF || mcnt_b !== 16'hFFFF) begin n_fail++; $display("FAIL sat_mcnt got=%h/%h exp=ffff", mcnt_a, mcnt_b); end
    n_checks++; if (ccnt_a !== 16'(m_ccnt) || mcnt_a !== 16'(m_mcnt)) begin n_fail++; $display("FAIL sat_mdl got=%h/%h exp=%h/%h", ccnt_a, mcnt_a, m_ccnt, m_mcnt); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1;
    test_reset();
    test_fill_hit();
    test_miss();
    test_cancel();
    test_stall();
    test_rbw();
    test_inv();
    test_reset_inflight();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
